// File: rtl/od_line_receiver.sv
// Receive-side conditioner for pulled-up wired-OR open-drain lines: per channel it
// synchronises the line, glitch-filters it, emits rise/fall strobes and flags stuck-low lines.
module od_line_receiver #(
  parameter int WIDTH   = 6,
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] line,
  input  logic             en,
  input  logic             stuck_clr,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] stuck
);

  localparam logic [7:0]  FILT_LAST = 8'(FILTER - 1);
  localparam logic [15:0] TMR_MAX   = 16'(TIMEOUT);

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  logic [WIDTH-1:0] level_r;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic [WIDTH-1:0] stuck_r;
  logic [7:0]       cnt_r [WIDTH];
  logic [15:0]      tmr_r [WIDTH];

  logic [WIDTH-1:0] s1_s;
  logic [WIDTH-1:0] level_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] stuck_s;
  logic [7:0]       cnt_s [WIDTH];
  logic [15:0]      tmr_s [WIDTH];

  // Any non-zero sample (1, z, x) counts as released-high.
  always_comb begin
    s1_s = {WIDTH{1'b1}};
    for (int i = 0; i < WIDTH; i++) begin
      if (line[i] == 1'b0) begin
        s1_s[i] = 1'b0;
      end else begin
        s1_s[i] = 1'b1;
      end
    end
  end

  // Next-state logic for glitch filter, strobes, low-timers and stuck flags.
  always_comb begin
    level_s = level_r;
    rise_s  = {WIDTH{1'b0}};
    fall_s  = {WIDTH{1'b0}};
    stuck_s = stuck_r;
    cnt_s   = cnt_r;
    tmr_s   = tmr_r;
    for (int i = 0; i < WIDTH; i++) begin
      if (!en) begin
        cnt_s[i] = 8'd0;
      end else if (s2_r[i] == level_r[i]) begin
        cnt_s[i] = 8'd0;
      end else if (cnt_r[i] == FILT_LAST) begin
        level_s[i] = s2_r[i];
        cnt_s[i]   = 8'd0;
        rise_s[i]  = s2_r[i];
        fall_s[i]  = ~s2_r[i];
      end else begin
        cnt_s[i] = cnt_r[i] + 8'd1;
      end

      // Timer counts only cycles already spent low, so stuck lands TIMEOUT cycles after fall.
      if (stuck_clr) begin
        tmr_s[i]   = 16'd0;
        stuck_s[i] = 1'b0;
      end else if (level_s[i]) begin
        tmr_s[i] = 16'd0;
      end else if (!level_r[i] && (tmr_r[i] != TMR_MAX)) begin
        tmr_s[i] = tmr_r[i] + 16'd1;
        if (tmr_r[i] == TMR_MAX - 16'd1) begin
          stuck_s[i] = 1'b1;
        end else begin
          stuck_s[i] = stuck_r[i];
        end
      end else begin
        tmr_s[i] = tmr_r[i];
      end
    end
  end

  // State registers; reset returns the bus to idle-high immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_r    <= {WIDTH{1'b1}};
      s2_r    <= {WIDTH{1'b1}};
      level_r <= {WIDTH{1'b1}};
      rise_r  <= {WIDTH{1'b0}};
      fall_r  <= {WIDTH{1'b0}};
      stuck_r <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= 8'd0;
        tmr_r[i] <= 16'd0;
      end
    end else begin
      s1_r    <= s1_s;
      s2_r    <= s1_r;
      level_r <= level_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
      stuck_r <= stuck_s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_s[i];
        tmr_r[i] <= tmr_s[i];
      end
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;
  assign stuck = stuck_r;

endmodule

// File: doc/od_line_receiver.md
Name: od_line_receiver

Overview:
Receive-side conditioner for wired-OR open-drain lines driven by the hex open-drain buffer stage. Each line is pulled up externally, so an undriven or released line reads high. Per channel, the block:
- synchronises the line into the clk domain
- applies a digital glitch filter
- reports the debounced level plus one-cycle rise/fall strobes
- flags lines held low longer than a timeout (stuck-bus detection)

Parameters:
WIDTH, 6, number of open-drain lines handled (one per buffer channel)
FILTER, 4, consecutive synchronised cycles a new value must persist before level changes; legal 1..255
TIMEOUT, 1000, cycles of continuous debounced low before stuck is raised; legal 2..65535

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
line  input  WIDTH  open-drain bus lines after pull-up; any non-0 sample (1, z, x) is treated as 1
en  input  1  filter enable; 0 freezes level/counters
stuck_clr  input  1  one-cycle pulse; clears all stuck bits and restarts low-timers
level  output  WIDTH  debounced line level
rise  output  WIDTH  one-cycle pulse when level goes 0->1
fall  output  WIDTH  one-cycle pulse when level goes 1->0
stuck  output  WIDTH  sticky per-line stuck-low flag

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-filter):
  - sync stages = all 1; level = all 1 (idle bus); rise = fall = stuck = 0
  - all filter counters and low-timers = 0
  - Outputs take these values immediately, not at the next edge.
- Synchroniser:
  - 2-flop chain per bit, s1 <= (line==0 ? 0 : 1), s2 <= s1.
  - Runs regardless of en.
  - A line change first appears on s2 at the 2nd rising edge after the change.
- Glitch filter, per bit, with en=1:
  - if s2 == level: cnt <= 0
  - else if cnt == FILTER-1: level <= s2, cnt <= 0, and rise or fall pulses per direction
  - else: cnt <= cnt+1
  - Total latency from line change to level change = 2+FILTER edges.
  - FILTER=1 gives a 3-edge latency with no filtering.
  - Any s2 excursion shorter than FILTER cycles is ignored and cnt returns to 0.
- rise/fall:
  - Registered, asserted exactly on the edge level changes, high for exactly one cycle.
  - rise and fall are never both high on the same bit.
  - Channels are independent; simultaneous changes on several bits produce simultaneous pulses.
- en=0:
  - cnt held at 0, level frozen, rise = fall = 0.
  - Low-timers and stuck keep operating on the frozen level.
  - On en returning to 1, filtering restarts from cnt=0.
- Stuck detection, per bit:
  - Timer tmr increments each cycle level==0 and saturates at TIMEOUT.
  - Timer resets to 0 on the cycle level becomes 1.
  - stuck bit sets on the edge tmr reaches TIMEOUT, i.e. TIMEOUT cycles after fall.
  - stuck stays set after level returns high, until stuck_clr.
  - stuck_clr=1 clears all stuck bits and all tmr to 0 on that edge.
  - stuck_clr has priority over a simultaneous set.
  - If the line is still low after stuck_clr, stuck re-asserts TIMEOUT cycles later.
- Counter widths: cnt is 8 bits; tmr is 16 bits. No wrap; both saturate/reset as above.

Test Plan:
- Reset then idle: rst low 3 cycles, line=6'b111111 -> level=111111, rise=fall=stuck=0. Assert rst asynchronously mid-cycle -> outputs return to reset values before the next clk edge.
- Clean fall, FILTER=4: line[0] 1->0 just after edge E0 -> level[0]=0 and fall[0]=1 after edge E6, fall[0]=0 after E7; other bits unchanged.
- Glitch reject, FILTER=4: line[2] low for 3 cycles then released -> level[2] stays 1, no fall pulse. Low for exactly 4 synchronised cycles -> one fall pulse.
- Simultaneous channels: line 111111->010101 in one cycle -> fall=101010 on a single edge. Release to 111111 -> rise=101010 on a single edge, 2+FILTER edges after release.
- Stuck, TIMEOUT=16: hold line[5] low -> stuck[5]=1 exactly 16 cycles after fall[5]. Release line -> stuck[5] stays 1. Pulse stuck_clr -> stuck=0. Repeat with line held low and stuck_clr at cycle 16 -> clear wins; re-set 16 cycles later.
- Enable freeze: en=0, toggle line[1] low for 10 cycles -> level frozen, no pulses. Set en=1 with line still low -> fall[1] FILTER edges later.
